// File: rtl/game_pkg.sv
// Shared codes for the N x N game controller: cell marks, winner codes,
// scan directions and the controller state enum.
package game_pkg;

  // Cell contents as stored in the packed board
  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] X     = 2'b01;
  localparam logic [1:0] O     = 2'b10;

  // Winner codes
  localparam logic [1:0] NONE  = 2'b00;
  localparam logic [1:0] X_WIN = 2'b01;
  localparam logic [1:0] O_WIN = 2'b10;
  localparam logic [1:0] DRAW  = 2'b11;

  // Line directions scanned after a move, in scan order
  localparam logic [1:0] DIR_H = 2'd0;
  localparam logic [1:0] DIR_V = 2'd1;
  localparam logic [1:0] DIR_D = 2'd2;
  localparam logic [1:0] DIR_A = 2'd3;

  typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;

  // Mark of the opposing player
  function automatic logic [1:0] other_mark(input logic [1:0] m);
    return (m == X) ? O : X;
  endfunction

endpackage

// File: rtl/game_controller_n_line_scanner.sv
// Combinational run-length scanner: counts consecutive cells equal to mark
// through (row, col) along one direction, both ways, clipped at the board
// edges and saturated at WIN_LEN.
module line_scanner
  import game_pkg::*;
#(
  parameter int N       = 3,
  parameter int WIN_LEN = 3
) (
  input  logic [2*N*N-1:0]       board,
  input  logic [$clog2(N)-1:0]   row,
  input  logic [$clog2(N)-1:0]   col,
  input  logic [1:0]             mark,
  input  logic [1:0]             dir,
  output logic [$clog2(N):0]     run
);

  localparam int RUN_W = $clog2(N) + 1;
  localparam int IW    = $clog2(2 * N * N);

  // Walk forward then backward from the latched cell until a mismatch or edge
  always_comb begin : scan
    int dr;
    int dc;
    int r;
    int c;
    int sgn;
    logic go;
    run = RUN_W'(1);
    dr  = 0;
    dc  = 1;
    case (dir)
      DIR_H:   begin dr = 0; dc = 1;  end
      DIR_V:   begin dr = 1; dc = 0;  end
      DIR_D:   begin dr = 1; dc = 1;  end
      default: begin dr = 1; dc = -1; end
    endcase
    for (int s = 0; s < 2; s++) begin
      sgn = (s == 0) ? 1 : -1;
      go  = 1'b1;
      for (int k = 1; k < N; k++) begin
        r = int'(row) + sgn * k * dr;
        c = int'(col) + sgn * k * dc;
        if (go && r >= 0 && r < N && c >= 0 && c < N && run < RUN_W'(WIN_LEN)) begin
          if (board[IW'(2 * (r * N + c)) +: 2] == mark) begin
            run = run + RUN_W'(1);
          end else begin
            go = 1'b0;
          end
        end else begin
          go = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/game_controller_n.sv
// N x N in-a-row game controller. Accepts one move at a time, then spends
// up to four cycles scanning the four lines through the new mark before
// either declaring a result or handing the turn to the other player.
module game_controller_n
  import game_pkg::*;
#(
  parameter int         N            = 3,
  parameter int         WIN_LEN      = 3,
  parameter logic [1:0] FIRST_PLAYER = 2'b01
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       new_game,
  input  logic                       move_valid,
  output logic                       move_ready,
  input  logic [$clog2(N)-1:0]       move_row,
  input  logic [$clog2(N)-1:0]       move_col,
  output logic                       move_err,
  output logic [2*N*N-1:0]           board,
  output logic [1:0]                 turn,
  output logic                       game_done,
  output logic [1:0]                 winner,
  output logic [$clog2(N*N+1)-1:0]   move_count
);

  localparam int CW    = $clog2(N);
  localparam int RUN_W = $clog2(N) + 1;
  localparam int CNT_W = $clog2(N * N + 1);
  localparam int IW    = $clog2(2 * N * N);

  state_t               state_q, state_n;
  logic [1:0]           dir_q, dir_n;
  logic [CW-1:0]        row_q, col_q, row_n, col_n;
  logic [2*N*N-1:0]     board_n;
  logic [1:0]           turn_n, winner_n;
  logic [CNT_W-1:0]     cnt_n;
  logic                 done_n, err_n, ready_n;
  logic                 in_range;
  logic [IW-1:0]        cell_base;
  logic [RUN_W-1:0]     run;

  // Full-width coordinate check; out-of-range offers never index the board
  assign in_range  = (int'(move_row) < N) && (int'(move_col) < N);
  assign cell_base = in_range ? IW'(2 * (int'(move_row) * N + int'(move_col))) : '0;

  line_scanner #(.N(N), .WIN_LEN(WIN_LEN)) u_scan (
    .board (board),
    .row   (row_q),
    .col   (col_q),
    .mark  (turn),
    .dir   (dir_q),
    .run   (run)
  );

  // Next-state and next-output logic; new_game overrides everything
  always_comb begin
    state_n  = state_q;
    dir_n    = dir_q;
    row_n    = row_q;
    col_n    = col_q;
    board_n  = board;
    turn_n   = turn;
    cnt_n    = move_count;
    done_n   = game_done;
    winner_n = winner;
    err_n    = 1'b0;
    ready_n  = move_ready;
    if (new_game) begin
      state_n  = IDLE;
      dir_n    = DIR_H;
      board_n  = '0;
      turn_n   = FIRST_PLAYER;
      cnt_n    = '0;
      done_n   = 1'b0;
      winner_n = NONE;
      ready_n  = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (move_valid) begin
            if (in_range && board[cell_base +: 2] == EMPTY) begin
              board_n[cell_base +: 2] = turn;
              cnt_n   = move_count + CNT_W'(1);
              row_n   = move_row;
              col_n   = move_col;
              dir_n   = DIR_H;
              state_n = CHECK;
              ready_n = 1'b0;
            end else begin
              err_n = 1'b1;
            end
          end
        end
        CHECK: begin
          if (run >= RUN_W'(WIN_LEN)) begin
            winner_n = (turn == X) ? X_WIN : O_WIN;
            done_n   = 1'b1;
            state_n  = DONE;
          end else if (dir_q == DIR_A) begin
            if (move_count == CNT_W'(N * N)) begin
              winner_n = DRAW;
              done_n   = 1'b1;
              state_n  = DONE;
            end else begin
              turn_n  = other_mark(turn);
              state_n = IDLE;
              ready_n = 1'b1;
            end
          end else begin
            dir_n = dir_q + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Control and visible game state, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      dir_q      <= DIR_H;
      board      <= '0;
      turn       <= FIRST_PLAYER;
      move_count <= '0;
      game_done  <= 1'b0;
      winner     <= NONE;
      move_err   <= 1'b0;
      move_ready <= 1'b1;
    end else begin
      state_q    <= state_n;
      dir_q      <= dir_n;
      board      <= board_n;
      turn       <= turn_n;
      move_count <= cnt_n;
      game_done  <= done_n;
      winner     <= winner_n;
      move_err   <= err_n;
      move_ready <= ready_n;
    end
  end

  // Latched coordinates of the move being scanned; only read during CHECK
  always_ff @(posedge clk) begin
    row_q <= row_n;
    col_q <= col_n;
  end

endmodule

// File: tb/tb_game_controller_n.sv
// Bench for game_controller_n: a 3x3 (win 3) and a 5x5 (win 4) instance
// checked every cycle against a game-rules model, plus literal expectations.
module tb_game_controller_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic ng0, mv0, ng1, mv1;
  logic [1:0] r0, c0;
  logic [2:0] r1, c1;
  logic rdy0, err0, done0, rdy1, err1, done1;
  logic [1:0] trn0, win0, trn1, win1;
  logic [3:0] cnt0;
  logic [4:0] cnt1;
  logic [17:0] brd0;
  logic [49:0] brd1;

  game_controller_n #(.N(3), .WIN_LEN(3)) dut0 (
    .clk(clk), .reset(reset), .new_game(ng0), .move_valid(mv0), .move_ready(rdy0),
    .move_row(r0), .move_col(c0), .move_err(err0), .board(brd0), .turn(trn0),
    .game_done(done0), .winner(win0), .move_count(cnt0));

  game_controller_n #(.N(5), .WIN_LEN(4)) dut1 (
    .clk(clk), .reset(reset), .new_game(ng1), .move_valid(mv1), .move_ready(rdy1),
    .move_row(r1), .move_col(c1), .move_err(err1), .board(brd1), .turn(trn1),
    .game_done(done1), .winner(win1), .move_count(cnt1));

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // ---------------- game-rules model ----------------
  int nn [2] = '{3, 5};
  int wl [2] = '{3, 4};
  int mb [2][8][8];
  int mturn [2], mcnt [2], mdone [2], mwin [2], mrdy [2], merr [2];
  int busy [2];   // cycles until the pending result of a move becomes visible
  int pend [2];   // 0 pass turn, 1 mover wins, 2 draw

  // True when some WIN_LEN window along direction d through (r,c) is all one mark
  function automatic bit line_win(int i, int r, int c, int d);
    int dr, dc, m, y, x;
    bit ok;
    case (d)
      0: begin dr = 0; dc = 1; end
      1: begin dr = 1; dc = 0; end
      2: begin dr = 1; dc = 1; end
      default: begin dr = 1; dc = -1; end
    endcase
    m = mb[i][r][c];
    for (int s = -(wl[i] - 1); s <= 0; s++) begin
      ok = 1'b1;
      for (int k = 0; k < wl[i]; k++) begin
        y = r + (s + k) * dr;
        x = c + (s + k) * dc;
        if (y < 0 || y >= nn[i] || x < 0 || x >= nn[i]) ok = 1'b0;
        else if (mb[i][y][x] != m) ok = 1'b0;
      end
      if (ok) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic void model_clear(int i);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) mb[i][r][c] = 0;
    mturn[i] = 1; mcnt[i] = 0; mdone[i] = 0; mwin[i] = 0;
    mrdy[i] = 1; merr[i] = 0; busy[i] = 0; pend[i] = 0;
  endfunction

  function automatic void model_step(int i, bit g, bit m, int r, int c);
    int fd;
    merr[i] = 0;
    if (g) begin
      model_clear(i);
    end else if (busy[i] > 0) begin
      busy[i]--;
      if (busy[i] == 0) begin
        if (pend[i] == 0) begin mturn[i] = 3 - mturn[i]; mrdy[i] = 1; end
        else if (pend[i] == 1) begin mdone[i] = 1; mwin[i] = mturn[i]; end
        else begin mdone[i] = 1; mwin[i] = 3; end
      end
    end else if (mdone[i] == 0 && m) begin
      if (r < nn[i] && c < nn[i] && mb[i][r][c] == 0) begin
        mb[i][r][c] = mturn[i];
        mcnt[i]++;
        mrdy[i] = 0;
        fd = -1;
        for (int d = 0; d < 4; d++) if (fd < 0 && line_win(i, r, c, d)) fd = d;
        if (fd >= 0) begin busy[i] = fd + 1; pend[i] = 1; end
        else begin busy[i] = 4; pend[i] = (mcnt[i] == nn[i] * nn[i]) ? 2 : 0; end
      end else begin
        merr[i] = 1;
      end
    end
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      model_clear(0);
      model_clear(1);
    end else begin
      model_step(0, ng0, mv0, int'(r0), int'(c0));
      model_step(1, ng1, mv1, int'(r1), int'(c1));
    end
  end

  // ---------------- DUT accessors ----------------
  function automatic int d_rdy(int i);  return (i == 0) ? int'(rdy0)  : int'(rdy1);  endfunction
  function automatic int d_err(int i);  return (i == 0) ? int'(err0)  : int'(err1);  endfunction
  function automatic int d_done(int i); return (i == 0) ? int'(done0) : int'(done1); endfunction
  function automatic int d_turn(int i); return (i == 0) ? int'(trn0)  : int'(trn1);  endfunction
  function automatic int d_win(int i);  return (i == 0) ? int'(win0)  : int'(win1);  endfunction
  function automatic int d_cnt(int i);  return (i == 0) ? int'(cnt0)  : int'(cnt1);  endfunction
  function automatic int d_cell(int i, int r, int c);
    return (i == 0) ? int'(brd0[2 * (r * 3 + c) +: 2]) : int'(brd1[2 * (r * 5 + c) +: 2]);
  endfunction

  // Every cycle, away from the active edge: all outputs of both instances
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("i%0d move_ready", i), d_rdy(i), mrdy[i]);
        chk($sformatf("i%0d move_err", i), d_err(i), merr[i]);
        chk($sformatf("i%0d turn", i), d_turn(i), mturn[i]);
        chk($sformatf("i%0d game_done", i), d_done(i), mdone[i]);
        chk($sformatf("i%0d winner", i), d_win(i), mwin[i]);
        chk($sformatf("i%0d move_count", i), d_cnt(i), mcnt[i]);
        for (int r = 0; r < nn[i]; r++)
          for (int c = 0; c < nn[i]; c++)
            chk($sformatf("i%0d cell(%0d,%0d)", i, r, c), d_cell(i, r, c), mb[i][r][c]);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic drive(int i, bit m, bit g, int r, int c);
    if (i == 0) begin mv0 = m; ng0 = g; r0 = r[1:0]; c0 = c[1:0]; end
    else        begin mv1 = m; ng1 = g; r1 = r[2:0]; c1 = c[2:0]; end
  endtask

  task automatic newgame(int i);
    drive(i, 1'b0, 1'b1, 0, 0);
    @(negedge clk);
    drive(i, 1'b0, 1'b0, 0, 0);
  endtask

  // Offer one move once ready; e returns move_err seen after the edge
  task automatic offer(int i, int r, int c, output int e);
    int t = 0;
    while (d_rdy(i) != 1 && t < 10) begin @(negedge clk); t++; end
    if (t >= 10) chk($sformatf("i%0d ready wait", i), d_rdy(i), 1);
    drive(i, 1'b1, 1'b0, r, c);
    @(negedge clk);
    e = d_err(i);
    drive(i, 1'b0, 1'b0, r, c);
  endtask

  // Cycles until the move's scan ends (ready again or game finished)
  task automatic settle(int i, output int cyc);
    cyc = 0;
    while (d_rdy(i) == 0 && d_done(i) == 0 && cyc < 8) begin @(negedge clk); cyc++; end
    if (cyc >= 8) chk($sformatf("i%0d scan end wait", i), cyc, 4);
  endtask

  int e, cyc;
  int dr_r [9] = '{0, 0, 0, 1, 1, 1, 2, 2, 2};
  int dr_c [9] = '{0, 1, 2, 1, 0, 2, 1, 0, 2};

  initial begin
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 0, 0);
    drive(1, 1'b0, 1'b0, 0, 0);
    repeat (2) @(negedge clk);
    reset  = 1'b0;
    chk_en = 1'b1;
    chk("reset ready", int'(rdy0), 1);
    chk("reset turn", int'(trn0), 1);
    chk("reset count", int'(cnt0), 0);
    chk("reset board", int'(brd0), 0);

    // X takes the top row, O at (1,0),(1,1)
    offer(0, 0, 0, e); settle(0, cyc);
    offer(0, 1, 0, e); settle(0, cyc);
    offer(0, 0, 1, e); settle(0, cyc);
    offer(0, 1, 1, e); settle(0, cyc);
    offer(0, 0, 2, e); settle(0, cyc);
    chk("xwin latency", cyc, 1);
    chk("xwin winner", int'(win0), 1);
    chk("xwin done", int'(done0), 1);
    chk("xwin board", int'(brd0), 661);
    chk("xwin count", int'(cnt0), 5);
    // A move offered in DONE is ignored without an error
    drive(0, 1'b1, 1'b0, 2, 2);
    @(negedge clk);
    chk("done ignores move err", int'(err0), 0);
    drive(0, 1'b0, 1'b0, 2, 2);
    chk("done board held", int'(brd0), 661);

    // Rejected offers: occupied cell and out-of-range row
    newgame(0);
    chk("new game board", int'(brd0), 0);
    offer(0, 1, 1, e); settle(0, cyc);
    chk("plain move latency", cyc, 4);
    offer(0, 1, 1, e);
    chk("occupied err", e, 1);
    chk("occupied board", int'(brd0), 256);
    chk("occupied turn", int'(trn0), 2);
    offer(0, 3, 0, e);
    chk("row3 err", e, 1);
    @(negedge clk);
    chk("err one cycle", int'(err0), 0);
    chk("row3 count", int'(cnt0), 1);

    // new_game with move_valid while a scan is in progress
    newgame(0);
    offer(0, 0, 0, e);
    drive(0, 1'b1, 1'b1, 2, 2);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 0, 0);
    chk("abort board", int'(brd0), 0);
    chk("abort turn", int'(trn0), 1);
    chk("abort ready", int'(rdy0), 1);
    chk("abort count", int'(cnt0), 0);

    // Full board without a line
    for (int k = 0; k < 9; k++) begin
      offer(0, dr_r[k], dr_c[k], e);
      settle(0, cyc);
    end
    chk("draw latency", cyc, 4);
    chk("draw winner", int'(win0), 3);
    chk("draw done", int'(done0), 1);
    chk("draw count", int'(cnt0), 9);

    // 5x5, four in a row: O on the anti-diagonal
    offer(1, 0, 0, e); settle(1, cyc);
    offer(1, 0, 4, e); settle(1, cyc);
    offer(1, 0, 1, e); settle(1, cyc);
    offer(1, 1, 3, e); settle(1, cyc);
    offer(1, 4, 4, e); settle(1, cyc);
    offer(1, 2, 2, e); settle(1, cyc);
    chk("run3 no win done", int'(done1), 0);
    chk("run3 no win ready", int'(rdy1), 1);
    offer(1, 3, 3, e); settle(1, cyc);
    offer(1, 3, 1, e); settle(1, cyc);
    chk("owin latency", cyc, 4);
    chk("owin winner", int'(win1), 2);
    chk("owin done", int'(done1), 1);

    // Asynchronous reset: instance 0 mid-scan, instance 1 in DONE
    newgame(0);
    offer(0, 2, 2, e);
    #2 reset = 1'b1;
    #1;
    chk("areset ready0", int'(rdy0), 1);
    chk("areset board0", int'(brd0), 0);
    chk("areset count0", int'(cnt0), 0);
    chk("areset turn0", int'(trn0), 1);
    chk("areset done1", int'(done1), 0);
    chk("areset winner1", int'(win1), 0);
    chk("areset board1", int'(brd1 != 50'd0), 0);
    chk("areset ready1", int'(rdy1), 1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("after reset ready0", int'(rdy0), 1);
    chk("after reset board0", int'(brd0), 0);
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
